// File: rtl/fpu_sqrt_sched_if.sv
// fpu_sqrt_sched_if: bundles the two requester channels, the response channel
// and the shared square-root unit connection of fpu_sqrt_sched.
// master = requesters/consumer/sqrt-unit side, slave = the scheduler itself.
interface fpu_sqrt_sched_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_data;
  logic [2:0]   req0_rm;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_data;
  logic [2:0]   req1_rm;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;

  logic [W-1:0] sq_in;
  logic [2:0]   sq_rm;
  logic         sq_act;
  logic [W-1:0] sq_out;
  logic [3:0]   sq_flags;
  logic         sq_done;

  logic         busy;

  modport master (
    output req0_valid, req0_data, req0_rm,
    output req1_valid, req1_data, req1_rm,
    output rsp_ready,
    output sq_out, sq_flags, sq_done,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  sq_in, sq_rm, sq_act,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_rm,
    input  req1_valid, req1_data, req1_rm,
    input  rsp_ready,
    input  sq_out, sq_flags, sq_done,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_flags,
    output sq_in, sq_rm, sq_act,
    output busy
  );
endinterface

// File: rtl/fpu_sqrt_sched.sv
// fpu_sqrt_sched: round-robin scheduler sharing one square-root unit between
// two requesters. One operation is in flight at a time:
// IDLE (grant) -> ISSUE (sq_act pulse) -> WAIT (unit busy) -> RESP (hold result).
// Optional feature: define FPSQ_WDOG_EN to add a WAIT watchdog that answers
// with a quiet NaN and the invalid flag after TIMEOUT cycles without sq_done.
module fpu_sqrt_sched #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  fpu_sqrt_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t       state;
  logic         last_grant;
  logic         pick1;
  logic         grant;
  logic [W-1:0] sq_in_q;
  logic [2:0]   sq_rm_q;
  logic         sq_act_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [W-1:0] rsp_data_q;
  logic [3:0]   rsp_flags_q;
  logic         busy_q;

`ifdef FPSQ_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wdog;
`else
  // TIMEOUT only matters with the watchdog; this empty block keeps it referenced
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Round-robin pick: on contention the requester not granted last time wins
  always_comb begin
    pick1 = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) pick1 = ~last_grant;
  end

  // Ready is only offered in IDLE and never while reset is asserted
  assign grant          = rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = grant && !pick1;
  assign bus.req1_ready = grant && pick1;

  assign bus.sq_in     = sq_in_q;
  assign bus.sq_rm     = sq_rm_q;
  assign bus.sq_act    = sq_act_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = busy_q;

  // Scheduler FSM with registered outputs; reset abandons any operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      sq_in_q     <= '0;
      sq_rm_q     <= '0;
      sq_act_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      busy_q      <= 1'b0;
`ifdef FPSQ_WDOG_EN
      wdog        <= '0;
`endif
    end else begin
      sq_act_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= ISSUE;
            busy_q     <= 1'b1;
            sq_act_q   <= 1'b1;
            last_grant <= pick1;
            rsp_id_q   <= pick1;
            sq_in_q    <= pick1 ? bus.req1_data : bus.req0_data;
            sq_rm_q    <= pick1 ? bus.req1_rm : bus.req0_rm;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef FPSQ_WDOG_EN
          wdog  <= '0;
`endif
        end
        WAIT: begin
          if (bus.sq_done) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.sq_out;
            rsp_flags_q <= bus.sq_flags;
          end
`ifdef FPSQ_WDOG_EN
          else if (wdog == CW'(TIMEOUT - 1)) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= W'(32'h7FC0_0000);
            rsp_flags_q <= 4'b0010;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sqrt_sched.sv
// tb_fpu_sqrt_sched: directed scoreboard bench for fpu_sqrt_sched.
// Expected responses are queued when requests are issued; a monitor pops and
// compares on every rsp_valid && rsp_ready. Define FPSQ_WDOG_EN to exercise
// the watchdog build (DUT uses TIMEOUT=8 here).
module tb_fpu_sqrt_sched;

  typedef struct {
    bit          id;
    logic [31:0] data;
    logic [3:0]  flags;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  // Sqrt unit model controls, written only by the main process
  bit          model_on;
  int          pulse_cnt;
  logic [31:0] pulse_data;
  logic [3:0]  pulse_flags;

  fpu_sqrt_sched_if #(.W(32)) bus ();

  fpu_sqrt_sched #(.W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void report_fail(string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endfunction

  function automatic void push_expect(bit id, logic [31:0] data, logic [3:0] flags);
    exp_t e;
    e.id = id;
    e.data = data;
    e.flags = flags;
    sb.push_back(e);
  endfunction

  // Hand-computed single-precision square roots: {flags, result}
  function automatic logic [35:0] sqrt_lookup(logic [31:0] x, logic [2:0] rm);
    case (x)
      32'h4080_0000: sqrt_lookup = {4'b0000, 32'h4000_0000};
      32'h4110_0000: sqrt_lookup = {4'b0000, 32'h4040_0000};
      32'h4180_0000: sqrt_lookup = {4'b0000, 32'h4080_0000};
      32'h4000_0000: sqrt_lookup = (rm == 3'd3) ? {4'b0001, 32'h3FB5_04F4}
                                                : {4'b0001, 32'h3FB5_04F3};
      32'hBF80_0000: sqrt_lookup = {4'b0010, 32'h7FC0_0000};
      default:       sqrt_lookup = {4'b1111, 32'hDEAD_BEEF};
    endcase
  endfunction

  // Shared sqrt unit: answers 5 cycles after sq_act, or emits forced pulses
  initial begin
    int          left;
    int          seen;
    logic [35:0] r;
    bus.sq_done  = 1'b0;
    bus.sq_out   = '0;
    bus.sq_flags = '0;
    left = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      bus.sq_done = 1'b0;
      if (pulse_cnt != seen) begin
        seen         = pulse_cnt;
        bus.sq_out   = pulse_data;
        bus.sq_flags = pulse_flags;
        bus.sq_done  = 1'b1;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          r            = sqrt_lookup(bus.sq_in, bus.sq_rm);
          bus.sq_out   = r[31:0];
          bus.sq_flags = r[35:32];
          bus.sq_done  = 1'b1;
        end
      end else if (bus.sq_act && model_on) begin
        left = 5;
      end
    end
  end

  // Monitor: handshake checks and scoreboard comparison
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        check_output("ready_onehot", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
        check_output("ready_only_idle", {31'b0, bus.busy}, 32'd0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got id=%0d data=%h expected no response",
                   bus.rsp_id, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          check_output("rsp_id", {31'b0, bus.rsp_id}, {31'b0, e.id});
          check_output("rsp_data", bus.rsp_data, e.data);
          check_output("rsp_flags", {28'b0, bus.rsp_flags}, {28'b0, e.flags});
        end
      end
    end
  end

  // Absolute time limit
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic set_req(input bit id, input bit v, input logic [31:0] d, input logic [2:0] rm);
    if (id) begin
      bus.req1_valid = v;
      bus.req1_data  = d;
      bus.req1_rm    = rm;
    end else begin
      bus.req0_valid = v;
      bus.req0_data  = d;
      bus.req0_rm    = rm;
    end
  endtask

  // Raise valid, wait for the grant cycle, drop valid after the accept edge;
  // returns at the negedge of the ISSUE cycle
  task automatic apply_stimulus(input bit id, input logic [31:0] d, input logic [2:0] rm,
                                output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    set_req(id, 1'b1, d, rm);
    while (!got && waited < 100) begin
      #1;
      if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    @(negedge clk);
    set_req(id, 1'b0, '0, '0);
    if (!got) begin
      report_fail("grant_wait");
      waited = -1;
    end
  endtask

  // Issue one request and count cycles from accept (cycle 0) to rsp_valid
  task automatic timed_request(input bit id, input logic [31:0] d, input logic [2:0] rm,
                               input int limit, output int waited, output int cyc);
    cyc = -1;
    apply_stimulus(id, d, rm, waited);
    if (waited >= 0) begin
      for (int c = 1; c <= limit; c++) begin
        #1;
        if (bus.rsp_valid) begin
          cyc = c;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  // Both requesters valid together; each drops valid once it is accepted
  task automatic issue_pair(input logic [31:0] d0, input logic [2:0] rm0,
                            input logic [31:0] d1, input logic [2:0] rm1);
    bit g0;
    bit g1;
    set_req(1'b0, 1'b1, d0, rm0);
    set_req(1'b1, 1'b1, d1, rm1);
    for (int i = 0; i < 100 && (bus.req0_valid || bus.req1_valid); i++) begin
      #1;
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      @(negedge clk);
      if (g0) set_req(1'b0, 1'b0, '0, '0);
      if (g1) set_req(1'b1, 1'b0, '0, '0);
    end
    if (bus.req0_valid || bus.req1_valid) begin
      report_fail("pair_grant");
      set_req(1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, '0, '0);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !bus.busy) done = 1'b1;
    end
    if (!done) report_fail("drain");
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_done(input logic [31:0] d, input logic [3:0] f);
    pulse_data  = d;
    pulse_flags = f;
    pulse_cnt++;
  endtask

  // Main directed sequence
  initial begin
    int waited;
    int cyc;
    checks    = 0;
    errors    = 0;
    model_on  = 1'b1;
    pulse_cnt = 0;
    pulse_data  = '0;
    pulse_flags = '0;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 1'b0, '0, '0);
    set_req(1'b0, 1'b1, 32'h4080_0000, 3'd0);

    // Reset state: every output low, even with a request pending
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
    check_output("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check_output("rst_busy", {31'b0, bus.busy}, 32'd0);
    check_output("rst_sq_act", {31'b0, bus.sq_act}, 32'd0);
    check_output("rst_sq_in", bus.sq_in, 32'd0);
    check_output("rst_rsp_data", bus.rsp_data, 32'd0);

    // sqrt(4.0): granted on the first edge after release, rsp_valid at cycle 7
    @(negedge clk);
    rst = 1'b1;
    push_expect(1'b0, 32'h4000_0000, 4'b0000);
    timed_request(1'b0, 32'h4080_0000, 3'd0, 40, waited, cyc);
    check_output("first_grant_wait", waited, 32'd0);
    check_output("latency_cycles", cyc, 32'd7);
    wait_drain();

    // Simultaneous pairs from reset: req0, req1, then req0, req1 again
    do_reset();
    push_expect(1'b0, 32'h4040_0000, 4'b0000);
    push_expect(1'b1, 32'h3FB5_04F4, 4'b0001);
    issue_pair(32'h4110_0000, 3'd0, 32'h4000_0000, 3'd3);
    wait_drain();
    push_expect(1'b0, 32'h3FB5_04F3, 4'b0001);
    push_expect(1'b1, 32'h7FC0_0000, 4'b0010);
    issue_pair(32'h4000_0000, 3'd1, 32'hBF80_0000, 3'd0);
    wait_drain();

    // Back-pressure: result held 10 cycles, no new grant, stray sq_done ignored
    bus.rsp_ready = 1'b0;
    push_expect(1'b1, 32'h4080_0000, 4'b0000);
    apply_stimulus(1'b1, 32'h4180_0000, 3'd0, waited);
    cyc = -1;
    for (int i = 0; i < 40 && cyc < 0; i++) begin
      #1;
      if (bus.rsp_valid) cyc = i;
      else @(negedge clk);
    end
    if (cyc < 0) report_fail("hold_rsp_valid");
    set_req(1'b0, 1'b1, 32'h4110_0000, 3'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_output("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check_output("hold_data", bus.rsp_data, 32'h4080_0000);
      check_output("hold_flags", {28'b0, bus.rsp_flags}, 32'd0);
      check_output("hold_id", {31'b0, bus.rsp_id}, 32'd1);
      check_output("hold_no_ready", {31'b0, bus.req0_ready}, 32'd0);
      if (i == 3) pulse_done(32'h1234_5678, 4'b1111);
      @(negedge clk);
    end
    // The waiting req0 withdraws before being granted and must not be served
    set_req(1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b1;
    wait_drain();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("withdrawn_busy", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
    end

    // sq_done in IDLE leaves the last result untouched
    pulse_done(32'hCAFE_F00D, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_output("idle_done_data", bus.rsp_data, 32'h4080_0000);
      check_output("idle_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
    end

    // Reset during WAIT abandons the operation; a late sq_done is ignored
    model_on = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b0, 32'h4080_0000, 3'd2, waited);
    repeat (2) @(negedge clk);
    #1;
    check_output("wait_busy", {31'b0, bus.busy}, 32'd1);
    check_output("wait_sq_rm", {29'b0, bus.sq_rm}, 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check_output("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check_output("midrst_sq_in", bus.sq_in, 32'd0);
    check_output("midrst_sq_rm", {29'b0, bus.sq_rm}, 32'd0);
    check_output("midrst_rsp_data", bus.rsp_data, 32'd0);
    check_output("midrst_rsp_id", {31'b0, bus.rsp_id}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulse_done(32'h4000_0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_output("postrst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check_output("postrst_busy", {31'b0, bus.busy}, 32'd0);
    end

    // Unit never answers: watchdog build times out, default build keeps waiting
    @(negedge clk);
`ifdef FPSQ_WDOG_EN
    push_expect(1'b0, 32'h7FC0_0000, 4'b0010);
    timed_request(1'b0, 32'h4110_0000, 3'd0, 40, waited, cyc);
    check_output("wdog_cycles", cyc, 32'd10);
    wait_drain();
`else
    timed_request(1'b0, 32'h4110_0000, 3'd0, 30, waited, cyc);
    check_output("nowdog_no_rsp", cyc, 32'hFFFF_FFFF);
    check_output("nowdog_busy", {31'b0, bus.busy}, 32'd1);
    do_reset();
`endif
    model_on = 1'b1;

    repeat (3) @(negedge clk);
    check_output("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
